// File: rtl/capture_seq_pkg.sv
// Shared types, defaults and sizing helpers for the RF capture sequencer.
package capture_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    WAIT  = 3'd2,
    BURST = 3'd3,
    STOP  = 3'd4
  } capture_state_e;

  localparam int unsigned DEF_BURST_WORDS  = 8192;
  localparam int unsigned DEF_FLUSH_CYCLES = 16;
  localparam int unsigned DEF_LEVEL_W      = 14;

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/capture_sequencer_rise_detect.sv
// Rising-edge detector: registers the previous input sample, flags in=1 after in=0.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev_q, prev_d;

  always_comb prev_d = din;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/capture_sequencer.sv
// Capture session sequencer: flush, write enable, FX3 burst pacing, sticky overflow flag.
// Optional burst statistics counter enabled by defining CAPTURE_SEQ_STATS_EN.
module capture_sequencer
  import capture_seq_pkg::*;
#(
  parameter int unsigned BURST_WORDS  = DEF_BURST_WORDS,
  parameter int unsigned LEVEL_W      = DEF_LEVEL_W,
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               collectData,
  input  logic               readData,
  input  logic [LEVEL_W-1:0] bufferLevel,
  input  logic               bufferOverflow,
  output logic               fifoFlush,
  output logic               isWriting,
  output logic               dataAvailable,
  output logic               fx3isReading,
  output logic               bufferError,
  output logic [31:0]        burstCount,
  output capture_state_e     dbg_state
);

  localparam int unsigned BCW = cnt_width(BURST_WORDS);
  localparam int unsigned FCW = cnt_width(FLUSH_CYCLES);
  localparam logic [BCW-1:0]     BURST_LAST = BCW'(BURST_WORDS - 1);
  localparam logic [FCW-1:0]     FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);
  localparam logic [LEVEL_W:0]   BURST_LVL  = (LEVEL_W + 1)'(BURST_WORDS);

  capture_state_e state_q, state_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
  logic fifo_flush_q, fifo_flush_d;
  logic is_writing_q, is_writing_d;
  logic data_avail_q, data_avail_d;
  logic reading_q, reading_d;
  logic buf_err_q, buf_err_d;
  logic read_rise;
  logic req;
  logic session_start;

  rise_detect u_read_rise (
    .clk  (clock),
    .rst  (reset),
    .din  (readData),
    .rise (read_rise)
  );

  // Only an edge seen while a full burst is already being offered counts.
  assign req = read_rise & data_avail_q;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (collectData) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_LAST;
        end
      end
      FLUSH: begin
        if (!collectData)            state_d = IDLE;
        else if (flush_cnt_q == '0)  state_d = WAIT;
        else                         flush_cnt_d = flush_cnt_q - 1'b1;
      end
      WAIT: begin
        if (req) begin
          state_d     = collectData ? BURST : STOP;
          burst_cnt_d = BURST_LAST;
        end else if (!collectData) begin
          state_d = IDLE;
        end
      end
      BURST, STOP: begin
        // A burst always runs to completion; collectData only picks the exit.
        if (burst_cnt_q == '0) begin
          state_d = (state_q == BURST && collectData) ? WAIT : IDLE;
        end else begin
          burst_cnt_d = burst_cnt_q - 1'b1;
          if (state_q == BURST && !collectData) state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign session_start = (state_q == IDLE) && (state_d == FLUSH);

  always_comb begin
    buf_err_d = buf_err_q;
    if (session_start)                          buf_err_d = 1'b0;
    else if (bufferOverflow && state_q != FLUSH) buf_err_d = 1'b1;

    fifo_flush_d = (state_d == FLUSH);
    is_writing_d = (state_d == WAIT) || (state_d == BURST);
    reading_d    = (state_d == BURST) || (state_d == STOP);
    data_avail_d = (state_d == WAIT) && ({1'b0, bufferLevel} >= BURST_LVL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      fifo_flush_q <= 1'b0;
      is_writing_q <= 1'b0;
      data_avail_q <= 1'b0;
      reading_q    <= 1'b0;
      buf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      fifo_flush_q <= fifo_flush_d;
      is_writing_q <= is_writing_d;
      data_avail_q <= data_avail_d;
      reading_q    <= reading_d;
      buf_err_q    <= buf_err_d;
    end
  end

`ifdef CAPTURE_SEQ_STATS_EN
  logic [31:0] burst_count_q, burst_count_d;

  always_comb begin
    burst_count_d = burst_count_q;
    if (session_start)
      burst_count_d = '0;
    else if ((state_q == BURST || state_q == STOP) && burst_cnt_q == '0)
      burst_count_d = burst_count_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) burst_count_q <= '0;
    else       burst_count_q <= burst_count_d;
  end

  assign burstCount = burst_count_q;
`else
  assign burstCount = 32'd0;
`endif

  assign fifoFlush     = fifo_flush_q;
  assign isWriting     = is_writing_q;
  assign dataAvailable = data_avail_q;
  assign fx3isReading  = reading_q;
  assign bufferError   = buf_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed-random bench for capture_sequencer: session timing, burst pacing, overflow, reset.
module tb_capture_sequencer;
  import capture_seq_pkg::*;

  localparam int BW = 8192;
  localparam int LW = 14;
  localparam int FC = 16;
`ifdef CAPTURE_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, collectData, readData, bufferOverflow;
  logic [LW-1:0] bufferLevel;
  logic fifoFlush, isWriting, dataAvailable, fx3isReading, bufferError;
  logic [31:0] burstCount;
  capture_state_e dbg_state;

  int checks = 0;
  int failures = 0;
  int sess_bursts = 0;
  logic [31:0] exp_q[$];

  capture_sequencer #(.BURST_WORDS(BW), .LEVEL_W(LW), .FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset(reset), .collectData(collectData), .readData(readData),
    .bufferLevel(bufferLevel), .bufferOverflow(bufferOverflow), .fifoFlush(fifoFlush),
    .isWriting(isWriting), .dataAvailable(dataAvailable), .fx3isReading(fx3isReading),
    .bufferError(bufferError), .burstCount(burstCount), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // driver and checker tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_outs"}, {28'd0, fifoFlush, isWriting, dataAvailable, fx3isReading}, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  function automatic logic [31:0] exp_count(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  // Starts a session from IDLE and checks the flush window and write-enable start.
  task automatic start_session(input string tag, input bit ovf);
    collectData = 1'b1;
    if (ovf) bufferOverflow = 1'b1;
    sess_bursts = 0;
    for (int k = 1; k <= FC + 1; k++) begin
      tick();
      if (k == 2) bufferOverflow = 1'b0;
      check({tag, "_flush"}, fifoFlush, (k <= FC));
      check({tag, "_wr"}, isWriting, (k > FC));
      if (k == 1 || k == FC) begin
        check({tag, "_err_clr"}, bufferError, 1'b0);
        check({tag, "_cnt_clr"}, burstCount, 32'd0);
      end
    end
  endtask

  task automatic do_request();
    readData = 1'b0;
    tick();
    readData = 1'b1;
    tick();
  endtask

  // Observes a running burst until the read strobe drops. isWriting is expected high
  // for the first drop_at strobe cycles, low afterwards.
  task automatic burst_measure(input int drop_at, input int reassert_at,
                               output int len, output int wr_err, output int av_err);
    len = 0; wr_err = 0; av_err = 0;
    while (fx3isReading === 1'b1 && len <= BW + 4) begin
      len++;
      if (isWriting !== (len <= drop_at)) wr_err++;
      if (dataAvailable !== 1'b0) av_err++;
      if (len == drop_at) collectData = 1'b0;
      if (len == reassert_at) collectData = 1'b1;
      readData = (len < 40) ? ($urandom_range(0, 1) != 0) : 1'b0;
      tick();
    end
  endtask

  task automatic score_burst(input string tag, input int drop_at, input int reassert_at);
    int len, wr_err, av_err;
    burst_measure(drop_at, reassert_at, len, wr_err, av_err);
    check({tag, "_len"}, 32'(len), exp_q.pop_front());
    check({tag, "_wr"}, 32'(wr_err), 32'd0);
    check({tag, "_avail"}, 32'(av_err), 32'd0);
    sess_bursts++;
  endtask

  function automatic logic [LW-1:0] high_level();
    return LW'($urandom_range(BW, (1 << LW) - 1));
  endfunction

  initial begin
    int n;
    reset = 1'b1; collectData = 1'b0; readData = 1'b0;
    bufferOverflow = 1'b0; bufferLevel = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_idle("rst");
    check("rst_err", bufferError, 1'b0);
    check("rst_cnt", burstCount, 32'd0);
    n = $urandom_range(2, 8);
    repeat (n) begin
      tick();
      check_idle("idle_wait");
    end

    // session start and flush window
    bufferLevel = LW'($urandom_range(0, BW - 1));
    start_session("s1", 1'b0);
    check("s1_avail_low", dataAvailable, 1'b0);

    // threshold: BW-1 offers nothing, a rise there is ignored
    bufferLevel = LW'(BW - 1);
    n = $urandom_range(3, 6);
    repeat (n) begin
      tick();
      check("s2_below", dataAvailable, 1'b0);
    end
    do_request();
    check("s2_ign_rd", fx3isReading, 1'b0);
    readData = 1'b0;
    bufferLevel = LW'(BW);
    check("s2_lag", dataAvailable, 1'b0);
    tick();
    check("s2_avail", dataAvailable, 1'b1);
    exp_q.push_back(32'(BW));
    do_request();
    check("s2_rd", fx3isReading, 1'b1);
    score_burst("s2", BW + 10, 0);
    check("s2_after_avail", dataAvailable, 1'b1);
    check("s2_after_wr", isWriting, 1'b1);
    check("s2_count", burstCount, exp_count(sess_bursts));

    // rise while not available is dropped; held-high is never a request
    bufferLevel = 14'd100;
    tick();
    readData = 1'b1;
    tick();
    check("s3_ign_rd", fx3isReading, 1'b0);
    check("s3_ign_av", dataAvailable, 1'b0);
    bufferLevel = high_level();
    n = $urandom_range(3, 10);
    repeat (n) begin
      tick();
      check("s3_hold_av", dataAvailable, 1'b1);
      check("s3_hold_rd", fx3isReading, 1'b0);
    end
    exp_q.push_back(32'(BW));
    do_request();
    check("s3_rd", fx3isReading, 1'b1);
    score_burst("s3", BW + 10, 0);
    check("s3_count", burstCount, exp_count(sess_bursts));

    // overflow in WAIT is sticky through IDLE, cleared by the next flush
    bufferOverflow = 1'b1;
    tick();
    bufferOverflow = 1'b0;
    check("s4_err_set", bufferError, 1'b1);
    collectData = 1'b0;
    tick();
    check_idle("s4_idle");
    check("s4_err_hold", bufferError, 1'b1);
    n = $urandom_range(2, 6);
    repeat (n) tick();
    check("s4_err_hold2", bufferError, 1'b1);
    start_session("s4", 1'b1);

    // collectData dropped mid-burst; re-raised while stopping must wait for IDLE
    bufferLevel = high_level();
    tick();
    exp_q.push_back(32'(BW));
    do_request();
    n = $urandom_range(50, 150);
    score_burst("s5", n, n + $urandom_range(5, 50));
    check_idle("s5_end");
    check("s5_count", burstCount, exp_count(sess_bursts));
    tick();
    check("s5_reflush", fifoFlush, 1'b1);
    repeat (FC) tick();
    check("s5_wr", isWriting, 1'b1);

    // request coinciding with collectData fall: burst runs with writing off
    readData = 1'b0;
    tick();
    readData = 1'b1;
    collectData = 1'b0;
    tick();
    check("s6_rd", fx3isReading, 1'b1);
    check("s6_wr", isWriting, 1'b0);
    exp_q.push_back(32'(BW));
    sess_bursts = 0;
    score_burst("s6", 0, 0);
    check_idle("s6_end");
    check("s6_count", burstCount, exp_count(sess_bursts));

    // reset mid-burst abandons it; next session flushes normally
    start_session("s7", 1'b0);
    bufferLevel = high_level();
    tick();
    do_request();
    readData = 1'b0;
    n = $urandom_range(10, 500);
    repeat (n) tick();
    check("s7_mid_rd", fx3isReading, 1'b1);
    bufferOverflow = 1'b1;
    tick();
    bufferOverflow = 1'b0;
    check("s7_err", bufferError, 1'b1);
    reset = 1'b1;
    tick();
    check_idle("s7_rst");
    check("s7_rst_err", bufferError, 1'b0);
    check("s7_rst_cnt", burstCount, 32'd0);
    reset = 1'b0;
    start_session("s7b", 1'b0);

    // collectData low in WAIT, then an aborted flush
    collectData = 1'b0;
    tick();
    check_idle("s8_wait_drop");
    collectData = 1'b1;
    n = $urandom_range(1, FC - 1);
    repeat (n) begin
      tick();
      check("s8_flush", fifoFlush, 1'b1);
    end
    collectData = 1'b0;
    tick();
    check_idle("s8_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
